// File: rtl/regfile_sweep_clear.sv
// Multi-entry register file with registered read ports and a post-reset clear sweep.
// Optional write-first bypass on same-address read/write: define REGFILE_BYPASS_EN.
module regfile_sweep_clear #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREGS     = 32,
  parameter logic [XLEN-1:0] RESET_VAL = '0,
  parameter string       ZERO_REG  = "TRUE",
  localparam int unsigned AW       = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic            ren_a,
  input  logic [AW-1:0]   raddr_a,
  output logic [XLEN-1:0] rdata_a,
  input  logic            ren_b,
  input  logic [AW-1:0]   raddr_b,
  output logic [XLEN-1:0] rdata_b,
  output logic            ready
);

  localparam bit ZERO_EN = (ZERO_REG == "TRUE");

  typedef enum logic {S_CLEAR, S_READY} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic            ready_q, ready_d;
  logic [XLEN-1:0] rdata_a_q, rdata_a_d;
  logic [XLEN-1:0] rdata_b_q, rdata_b_d;
  logic [XLEN-1:0] mem [NREGS];
  logic            wr_ok_c;

  // A write lands only in READY, in range, and never on a hard-wired zero entry.
  assign wr_ok_c = (state_q == S_READY) && we && (32'(waddr) < NREGS) &&
                   !(ZERO_EN && (waddr == '0));

  function automatic logic [XLEN-1:0] rd_sel(input logic [AW-1:0]   addr,
                                              input logic [XLEN-1:0] word);
    logic [XLEN-1:0] v;
    v = word;
    if (32'(addr) >= NREGS) begin
      v = '0;
    end else if (ZERO_EN && (addr == '0)) begin
      v = '0;
    end
    return v;
  endfunction

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready_d   = ready_q;
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    if (state_q == S_CLEAR) begin
      if (clr_idx_q == AW'(NREGS - 1)) begin
        state_d = S_READY;
        ready_d = 1'b1;
      end else begin
        clr_idx_d = clr_idx_q + AW'(1);
      end
    end else begin
      if (ren_a) begin
        rdata_a_d = rd_sel(raddr_a, mem[raddr_a]);
`ifdef REGFILE_BYPASS_EN
        if (wr_ok_c && (raddr_a == waddr)) rdata_a_d = wdata;
`endif
      end
      if (ren_b) begin
        rdata_b_d = rd_sel(raddr_b, mem[raddr_b]);
`ifdef REGFILE_BYPASS_EN
        if (wr_ok_c && (raddr_b == waddr)) rdata_b_d = wdata;
`endif
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  // Storage has no reset so it can map onto RAM; the sweep initialises it instead.
  always_ff @(posedge clock) begin
    if (!reset && (state_q == S_CLEAR)) begin
      mem[clr_idx_q] <= RESET_VAL;
    end else if (wr_ok_c) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;
  assign ready   = ready_q;

endmodule

// File: tb/tb_regfile_sweep_clear.sv
// Directed bench: a 32-entry instance (RESET_VAL 5A5A5A5A) and a 24-entry instance (RESET_VAL 0).
module tb_regfile_sweep_clear;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [31:0] P = 32'h5A5A5A5A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        u0_rst, u0_we, u0_ren_a, u0_ren_b, u0_ready;
  logic [4:0]  u0_waddr, u0_raddr_a, u0_raddr_b;
  logic [31:0] u0_wdata, u0_rdata_a, u0_rdata_b;

  logic        u1_rst, u1_we, u1_ren_a, u1_ren_b, u1_ready;
  logic [4:0]  u1_waddr, u1_raddr_a, u1_raddr_b;
  logic [31:0] u1_wdata, u1_rdata_a, u1_rdata_b;

  regfile_sweep_clear #(.XLEN(32), .NREGS(32), .RESET_VAL(P), .ZERO_REG("TRUE")) u0 (
    .clock(clk), .reset(u0_rst), .we(u0_we), .waddr(u0_waddr), .wdata(u0_wdata),
    .ren_a(u0_ren_a), .raddr_a(u0_raddr_a), .rdata_a(u0_rdata_a),
    .ren_b(u0_ren_b), .raddr_b(u0_raddr_b), .rdata_b(u0_rdata_b), .ready(u0_ready));

  regfile_sweep_clear #(.XLEN(32), .NREGS(24), .RESET_VAL(32'h0), .ZERO_REG("TRUE")) u1 (
    .clock(clk), .reset(u1_rst), .we(u1_we), .waddr(u1_waddr), .wdata(u1_wdata),
    .ren_a(u1_ren_a), .raddr_a(u1_raddr_a), .rdata_a(u1_rdata_a),
    .ren_b(u1_ren_b), .raddr_b(u1_raddr_b), .rdata_b(u1_rdata_b), .ready(u1_ready));

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        ren_a;
    logic [4:0]  raddr_a;
    logic        ren_b;
    logic [4:0]  raddr_b;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic u0_drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                          input logic ra_en, input logic [4:0] ra,
                          input logic rb_en, input logic [4:0] rb);
    u0_we = we; u0_waddr = wa; u0_wdata = wd;
    u0_ren_a = ra_en; u0_raddr_a = ra; u0_ren_b = rb_en; u0_raddr_b = rb;
  endtask

  task automatic u1_drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                          input logic ra_en, input logic [4:0] ra,
                          input logic rb_en, input logic [4:0] rb);
    u1_we = we; u1_waddr = wa; u1_wdata = wd;
    u1_ren_a = ra_en; u1_raddr_a = ra; u1_ren_b = rb_en; u1_raddr_b = rb;
  endtask

  initial begin
    // we, waddr, wdata, ren_a, raddr_a, ren_b, raddr_b, exp_a, exp_b
    vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd17, 1'b1, 5'd31, P, P};
    vecs[1]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  1'b0, 5'd0,  P, P};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  1'b0, 5'd0,  32'hDEADBEEF, P};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd5,  1'b0, 5'd0,  32'hDEADBEEF, P};
    vecs[4]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  1'b0, 5'd0,  32'hDEADBEEF, P};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b1, 5'd0,  32'h0, 32'h0};
    vecs[6]  = '{1'b1, 5'd7,  32'h11111111, 1'b0, 5'd0,  1'b0, 5'd0,  32'h0, 32'h0};
    vecs[7]  = '{1'b1, 5'd7,  32'h22222222, 1'b1, 5'd5,  1'b1, 5'd7,
                 32'hDEADBEEF, BYP ? 32'h22222222 : 32'h11111111};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b1, 5'd7,  32'h22222222, 32'h22222222};
    vecs[9]  = '{1'b1, 5'd0,  32'h12345678, 1'b1, 5'd0,  1'b1, 5'd5,  32'h0, 32'hDEADBEEF};
    vecs[10] = '{1'b1, 5'd31, 32'hCAFEF00D, 1'b1, 5'd31, 1'b0, 5'd0,
                 BYP ? 32'hCAFEF00D : P, 32'hDEADBEEF};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 1'b1, 5'd30, 32'hCAFEF00D, P};

    u0_rst = 1'b1; u1_rst = 1'b1;
    u0_drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
    u1_drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
    tick(); tick();
    chk("reset_ready", 32'(u0_ready), 32'h0);
    chk("reset_rdata_a", u0_rdata_a, 32'h0);
    chk("reset_rdata_b", u0_rdata_b, 32'h0);
    chk("reset_ready_u1", 32'(u1_ready), 32'h0);

    // Clear sweep with a read request held on, which must be ignored.
    u0_rst = 1'b0;
    u0_drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd17, 1'b0, 5'd0);
    for (int i = 1; i <= 32; i++) begin
      tick();
      chk($sformatf("sweep_ready_%0d", i), 32'(u0_ready), (i == 32) ? 32'h1 : 32'h0);
      chk($sformatf("sweep_rdata_a_%0d", i), u0_rdata_a, 32'h0);
    end

    for (int v = 0; v < 12; v++) begin
      u0_drive(vecs[v].we, vecs[v].waddr, vecs[v].wdata,
               vecs[v].ren_a, vecs[v].raddr_a, vecs[v].ren_b, vecs[v].raddr_b);
      tick();
      chk($sformatf("vec%0d_rdata_a", v), u0_rdata_a, vecs[v].exp_a);
      chk($sformatf("vec%0d_rdata_b", v), u0_rdata_b, vecs[v].exp_b);
    end
    u0_drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);

    // Reset while READY: outputs drop without waiting for a clock edge.
    u0_rst = 1'b1;
    #1;
    chk("async_ready", 32'(u0_ready), 32'h0);
    chk("async_rdata_a", u0_rdata_a, 32'h0);
    chk("async_rdata_b", u0_rdata_b, 32'h0);
    tick();
    u0_rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    u0_rst = 1'b1;
    #1;
    chk("midsweep_ready", 32'(u0_ready), 32'h0);
    tick(); tick();
    u0_rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      chk($sformatf("resweep_ready_%0d", i), 32'(u0_ready), (i == 32) ? 32'h1 : 32'h0);
    end
    u0_drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd7);
    tick();
    chk("recleared_5", u0_rdata_a, P);
    chk("recleared_7", u0_rdata_b, P);

    // 24-entry instance: writes held during the sweep must not land.
    u1_rst = 1'b0;
    u1_drive(1'b1, 5'd3, 32'h0000ABCD, 1'b1, 5'd3, 1'b0, 5'd0);
    for (int i = 1; i <= 24; i++) begin
      tick();
      chk($sformatf("u1_sweep_ready_%0d", i), 32'(u1_ready), (i == 24) ? 32'h1 : 32'h0);
    end
    chk("u1_sweep_rdata_a", u1_rdata_a, 32'h0);
    u1_drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd23);
    tick();
    chk("u1_entry3_cleared", u1_rdata_a, 32'h0);
    chk("u1_entry23_cleared", u1_rdata_b, 32'h0);
    u1_drive(1'b1, 5'd3, 32'h0000ABCD, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    u1_drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd3);
    tick();
    chk("u1_entry3_written_a", u1_rdata_a, 32'h0000ABCD);
    chk("u1_entry3_written_b", u1_rdata_b, 32'h0000ABCD);
    u1_drive(1'b1, 5'd30, 32'h00000777, 1'b1, 5'd30, 1'b0, 5'd0);
    tick();
    chk("u1_oor_read_a", u1_rdata_a, 32'h0);
    chk("u1_hold_b", u1_rdata_b, 32'h0000ABCD);
    u1_drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd30);
    tick();
    chk("u1_oor_read_b", u1_rdata_b, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_sweep_clear.md
Name: regfile_sweep_clear

Overview:
- Parametrised multi-entry successor to the single-word load register.
- Holds NREGS words of XLEN bits, with one write port and two read ports whose outputs are registered.
- After reset it clears its own storage one entry per clock, so it maps onto RAM, which has no reset.
- Serves as the integer register file of the multicycle RV32I datapath.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of entries; must be at least 2. AW = $clog2(NREGS) is the address width.
- RESET_VAL, 0, value written into every entry during the clear sweep.
- ZERO_REG, "TRUE", when "TRUE" entry 0 reads as 0 and ignores writes.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  XLEN  write data.
- ren_a  in  1  read enable, port A.
- raddr_a  in  AW  read address, port A.
- rdata_a  out  XLEN  registered read data, port A.
- ren_b  in  1  read enable, port B.
- raddr_b  in  AW  read address, port B.
- rdata_b  out  XLEN  registered read data, port B.
- ready  out  1  high once the clear sweep is complete.

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted:
  - state = CLEAR, clr_idx = 0, ready = 0, rdata_a = rdata_b = 0.
  - Storage contents are not reset directly.
- State CLEAR:
  - Each posedge writes RESET_VAL to mem[clr_idx] and increments clr_idx.
  - On the posedge that writes entry NREGS-1, state goes to READY and ready goes to 1.
  - The first posedge after reset release writes entry 0, so ready rises exactly NREGS clocks after release.
  - we, ren_a and ren_b are ignored; both rdata outputs stay 0.
- State READY:
  - Write: on posedge with we=1, mem[waddr] <= wdata.
  - The write is suppressed when waddr >= NREGS.
  - The write is also suppressed when ZERO_REG="TRUE" and waddr = 0.
  - Read: on posedge with ren_x=1, rdata_x <= mem[raddr_x]. Latency is 1 clock. With ren_x=0, rdata_x holds its value.
  - A read address >= NREGS loads 0.
  - When ZERO_REG="TRUE", raddr_x = 0 loads 0 regardless of storage contents.
  - Both ports may read the same address in the same cycle and return identical data.
  - Simultaneous write and read of the same address, without the bypass feature: the read returns the old (pre-write) value.
- Reset asserted mid-sweep or mid-operation: the sweep restarts from entry 0 and ready drops immediately (asynchronously).
- READY is left only via reset; there is no other way back to CLEAR.
- clr_idx is AW bits wide and counts 0..NREGS-1 with no wrap. It is frozen in READY.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: in READY, if we=1, ren_x=1 and raddr_x == waddr, and the write is not suppressed, then rdata_x <= wdata (write-first behaviour).
  - A suppressed write (x0, or address out of range) is never bypassed.
- Undefined: read-first behaviour; the old stored value is returned.
- In both cases, storage contents after the clock edge are identical.

Test Plan:
- Clear sweep: release reset with NREGS=32, RESET_VAL=32'h5A5A5A5A. Required: ready=0 for 31 posedges and 1 after the 32nd. A read of entry 17 then returns 32'h5A5A5A5A.
- Basic write/read: write 32'hDEADBEEF to entry 5, then ren_a=1, raddr_a=5 next cycle. Required: rdata_a=32'hDEADBEEF one clock later. rdata_a holds after ren_a drops to 0.
- Zero register: write 32'hFFFFFFFF to entry 0, then read entry 0 on both ports. Required: rdata_a = rdata_b = 0.
- Same-cycle read/write: entry 7 holds 32'h11111111; write 32'h22222222 to entry 7 while port B reads entry 7. Required: rdata_b = 32'h11111111 without REGFILE_BYPASS_EN and 32'h22222222 with it. Either way, the next read returns 32'h22222222.
- Reset mid-sweep: assert reset at clr_idx=10, then release. Required: ready falls immediately, rdata outputs are 0, and ready rises exactly 32 clocks after release.
- Write during CLEAR and out-of-range access: use NREGS=24 with RESET_VAL=0, and hold we=1, waddr=3, wdata=32'hABCD during the sweep. Required: entry 3 reads 0 after ready. Then read address 30 in READY. Required: rdata = 0.
